inet_checksum: RTL

INET_CHECKSUM -- requirements
Module: inet_checksum

---
 rtl/inet_checksum.sv | 109 ++++++++++
 1 files changed

// File: rtl/inet_checksum.sv
// Streaming one's-complement (RFC 1071) checksum with a seedable partial sum and kept-byte count.
// Latency: tvalid is high in the 3rd cycle after the tlast cycle (two fold stages), independent of data.
// Backpressure: input is stalled from tlast until the result handshake; the result is held until axis_o_tready.
module inet_checksum #(
    parameter int AXIS_BYTES = 2,
    parameter int UDP_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    sresetn,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
    input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic [15:0]             csum_seed,
    input  logic                    axis_o_tready,
    output logic                    axis_o_tvalid,
    output logic [15:0]             axis_o_csum,
    output logic [15:0]             axis_o_len
);
    localparam int NUM_WORDS = AXIS_BYTES / 2;

    generate
        if (AXIS_BYTES != 2 && AXIS_BYTES != 4 && AXIS_BYTES != 8 && AXIS_BYTES != 16) begin : g_bad_width
            $error("inet_checksum: AXIS_BYTES must be 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {ACCUM, FOLD1, FOLD2, OUT} state_t;

    state_t                  state;
    logic [31:0]             acc;
    logic [15:0]             len;
    logic                    first;
    logic [15:0]             csum_q;
    logic [AXIS_BYTES*8-1:0] masked_dat;
    logic [31:0]             beat_sum;
    logic [15:0]             beat_cnt;
    logic [15:0]             folded;
    logic [15:0]             inv;

    always_comb begin
        masked_dat = '0;
        beat_sum   = '0;
        beat_cnt   = '0;
        for (int j = 0; j < AXIS_BYTES; j++) begin
            masked_dat[8*j +: 8] = axis_i_tdata[8*j +: 8] & {8{axis_i_tkeep[j]}};
            beat_cnt = beat_cnt + {15'h0, axis_i_tkeep[j]};
        end
        for (int i = 0; i < NUM_WORDS; i++) begin
            beat_sum = beat_sum + {16'h0, masked_dat[16*i +: 16]};
        end
    end

    // After the first fold acc is at most 0x1FFFE, so one more end-around carry is final.
    assign folded = acc[15:0] + {15'h0, acc[16]};
    assign inv    = ~folded;

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state         <= ACCUM;
            acc           <= '0;
            len           <= '0;
            first         <= 1'b1;
            csum_q        <= '0;
            axis_i_tready <= 1'b1;
            axis_o_tvalid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (axis_i_tvalid && axis_i_tready) begin
                        acc   <= (first ? {16'h0, csum_seed} : acc) + beat_sum;
                        len   <= (first ? 16'h0 : len) + beat_cnt;
                        first <= 1'b0;
                        if (axis_i_tlast) begin
                            state         <= FOLD1;
                            axis_i_tready <= 1'b0;
                        end
                    end
                end
                FOLD1: begin
                    acc   <= {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
                    state <= FOLD2;
                end
                FOLD2: begin
                    acc           <= {16'h0, folded};
                    csum_q        <= (UDP_MODE != 0 && inv == 16'h0000) ? 16'hFFFF : inv;
                    axis_o_tvalid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (axis_o_tready) begin
                        state         <= ACCUM;
                        acc           <= '0;
                        len           <= '0;
                        first         <= 1'b1;
                        axis_o_tvalid <= 1'b0;
                        axis_i_tready <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign axis_o_csum = csum_q;
    assign axis_o_len  = len;

endmodule
